// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between the requesters and the shared logic-op arbiter.
// Handshake: req is a level held until the matching done pulse; operands are captured on grant.
interface logic_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     op;
    logic [WIDTH*NUM_REQ-1:0] a_in;
    logic [WIDTH*NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         result;
    logic                     busy;

    modport master (
        output req, op, a_in, b_in,
        input  grant, done, result, busy
    );

    modport slave (
        input  req, op, a_in, b_in,
        output grant, done, result, busy
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NOT unit among NUM_REQ requesters.
// Each operation walks IDLE -> EXEC -> RESP, so one result completes every three cycles.
module logic_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    logic_op_arbiter_if.slave    bus,
    output logic [1:0]           state_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    int                   scan_idx;
    logic [WIDTH-1:0]     alu_val;

    // Search starts at ptr and wraps, so the last winner is considered last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!sel_found && bus.req[IDX_W'(scan_idx)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        alu_val = '0;
        unique case (op_q)
            2'd0:    alu_val = a_q & b_q;
            2'd1:    alu_val = a_q | b_q;
            2'd2:    alu_val = a_q ^ b_q;
            default: alu_val = ~a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        grant_d  = grant_q;
        done_d   = done_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    win_d   = sel_idx;
                    op_d    = 2'(bus.op >> (2 * int'(sel_idx)));
                    a_d     = WIDTH'(bus.a_in >> (WIDTH * int'(sel_idx)));
                    b_d     = WIDTH'(bus.b_in >> (WIDTH * int'(sel_idx)));
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_val;
                done_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
                grant_d  = '0;
                ptr_d    = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);
                state_d  = RESP;
            end
            RESP: begin
                // req is deliberately ignored here so the winner can drop it.
                done_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != IDLE);
    assign state_o    = state_q;
endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit logic microoperation unit (AND/OR/XOR/NOT) among several requesters. Each requester presents an opcode and two operands under a level request. The block grants one requester at a time, latches its operands, and executes the operation on the shared datapath. It then returns the result with a one-cycle done pulse to the winner. It sits between the processor-side requesters and the logic datapath, replacing direct per-requester instantiation.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/result width
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  level request per requester; held until its done pulse
- op  in  2*NUM_REQ  opcode per requester, requester i at [2i+1:2i]
- a_in  in  WIDTH*NUM_REQ  operand A (processor register) per requester, i at [WIDTH*i +: WIDTH]
- b_in  in  WIDTH*NUM_REQ  operand B per requester, same packing
- grant  out  NUM_REQ  one-hot, registered; high for the requester being served
- done  out  NUM_REQ  one-hot one-cycle pulse, registered; result valid for that requester
- result  out  WIDTH  registered result of last completed operation
- busy  out  1  high whenever state is not IDLE

## Operation
- Opcodes: 0 = A & B; 1 = A | B; 2 = A ^ B; 3 = ~A (B ignored). Result width is WIDTH, with no carries.
- FSM states IDLE, EXEC, RESP. Encoding is free.
- IDLE: if req != 0, pick the winner by round-robin, starting the search at priority pointer ptr and ascending modulo NUM_REQ; the first set req bit wins.
  - On that edge: latch the winner's op/a/b and index, set grant to the winner's one-hot, go to EXEC.
  - If req == 0, stay in IDLE.
- EXEC: compute op(A,B) on the latched operands. On the edge:
  - result <= value
  - done <= one-hot(winner)
  - grant <= 0
  - ptr <= (winner+1) mod NUM_REQ
  - go to RESP
- RESP: done is high for exactly this cycle. req is ignored in this cycle, so the winner has this cycle to drop req. On the edge: done <= 0, go to IDLE.
- Operands are latched at grant. A requester that changes op/a/b or drops req during EXEC does not affect the in-flight result; the operation completes and done still pulses.
- A requester holding req through its done pulse is eligible again, but only after the others by round-robin order.
- result holds its value between operations. It changes only on the EXEC→RESP edge.
- Reset values: state IDLE, grant 0, done 0, result 0, ptr 0, busy 0, latched operands 0.
- Reset mid-operation, in EXEC or RESP: the operation is aborted, no done is issued, and ptr returns to 0.

## Timing
- Request sampled at edge k (state IDLE) → grant visible after edge k.
- Result and done visible after edge k+1.
- IDLE again after edge k+2.
- Service latency is 2 cycles from the sampling edge to done. Throughput is 1 operation per 3 cycles under continuous requests.
- busy rises after edge k and falls after edge k+2.
- At most one bit of grant and one bit of done is set in any cycle. grant and done are never high in the same cycle.
- Simultaneous requests are resolved solely by ptr. No requester is starved: a continuously asserted req is served within NUM_REQ operations.

## Test plan
- Reset, then single request: req=0001, op0=0, a0=4'b1100, b0=4'b1010. Required: grant=0001 one cycle after sampling; result=4'b1000 with done=0001 the next cycle; busy low after 3 cycles.
- Opcode sweep on requester 2 with a=4'b0110, b=4'b0011, ops 0..3. Required results: 4'b0010, 4'b0111, 4'b0101, 4'b1001, each accompanied by done=0100.
- Contention: req=1111 held continuously from reset. Required grant order: 0001, 0010, 0100, 1000, 0001. Each done matches the preceding grant, with an operation every 3 cycles.
- Pointer fairness: serve requester 1, then assert req=0011. Required: requester 0 is granted next, because ptr=2 wraps to 0 before reaching 1.
- Operand stability: during EXEC, change a_in/op of the granted requester and drop its req. Required: result reflects the latched values and done still pulses.
- Reset mid-operation: assert reset in the EXEC cycle. Required: no done pulse; after reset, grant=0, result=0, busy=0, and the next contention starts from requester 0.
